// File: rtl/sparc_exu_rrarb_n.sv
// Weighted round-robin arbiter with lock; combinational (zero-cycle) grant from state and req_vec.
// advance retires or extends the current grantee; no grant is held without a matching request.
module sparc_exu_rrarb_n #(
  parameter int N  = 4,
  parameter int CW = 2,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            se,
  input  logic [N-1:0]    req_vec,
  input  logic            advance,
  input  logic            lock,
  input  logic [N*CW-1:0] weight_vec,
  output logic [N-1:0]    grant_vec,
  output logic            grant_vld,
  output logic [IW-1:0]   grant_id
);

  logic [N-1:0]  park;
  logic          owner_vld;
  logic [IW-1:0] owner_id;
  logic [CW-1:0] cnt;

  logic [IW-1:0] park_idx;
  logic          owner_hit;
  logic          found;
  logic [IW-1:0] gnt_id;
  logic [CW-1:0] ecnt;
  logic [CW-1:0] wsel;

  logic unused_se;
  assign unused_se = se;

  always_comb begin
    park_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (park[i]) park_idx = IW'(i);
    end
  end

  assign owner_hit = owner_vld & req_vec[owner_id];

  // Owner keeps the grant while it still requests; otherwise search circularly past the park holder.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_t;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    idx_t  = '0;
    if (owner_hit) begin
      found  = 1'b1;
      gnt_id = owner_id;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx   = (int'(park_idx) + k) % N;
        idx_t = IW'(idx);
        if (!found && req_vec[idx_t]) begin
          found  = 1'b1;
          gnt_id = idx_t;
        end
      end
    end
  end

  assign grant_vld = found;
  assign grant_id  = gnt_id;
  assign grant_vec = found ? (N'(1) << gnt_id) : '0;

  assign wsel = weight_vec[int'(gnt_id)*CW +: CW];
  assign ecnt = (owner_vld && (gnt_id == owner_id)) ? cnt : '0;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      park      <= {1'b1, {(N-1){1'b0}}};
      owner_vld <= 1'b0;
      owner_id  <= '0;
      cnt       <= '0;
    end else if (advance && found) begin
      if (lock) begin
        owner_vld <= 1'b1;
        owner_id  <= gnt_id;
        cnt       <= ecnt;
      end else if (ecnt < wsel) begin
        owner_vld <= 1'b1;
        owner_id  <= gnt_id;
        cnt       <= ecnt + CW'(1);
      end else begin
        // Burst used up (or weight lowered below count): grantee drops to lowest priority.
        owner_vld <= 1'b0;
        cnt       <= '0;
        park      <= grant_vec;
      end
    end else if (owner_vld && !req_vec[owner_id]) begin
      owner_vld <= 1'b0;
      cnt       <= '0;
      park      <= N'(1) << owner_id;
    end
  end

endmodule

// File: tb/tb_sparc_exu_rrarb_n.sv
// Bench for sparc_exu_rrarb_n: directed vector table, hand sequences, random run against a rule model.
module tb_sparc_exu_rrarb_n;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            arst_l = 1'b0;
  logic            se = 1'b0;
  logic [N-1:0]    req_vec = '0;
  logic            advance = 1'b0;
  logic            lock = 1'b0;
  logic [N*CW-1:0] weight_vec = '0;
  logic [N-1:0]    grant_vec;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;

  sparc_exu_rrarb_n #(.N(N), .CW(CW)) dut (
    .clk(clk), .arst_l(arst_l), .se(se), .req_vec(req_vec), .advance(advance),
    .lock(lock), .weight_vec(weight_vec), .grant_vec(grant_vec),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: park as an index, owner as plain integers.
  int m_park;
  int m_ovld;
  int m_oid;
  int m_cnt;

  typedef struct {
    bit              rst;
    logic [N-1:0]    req;
    bit              adv;
    bit              lk;
    logic [N*CW-1:0] wt;
    int              exp_id;
    int              exp_vld;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_park = N - 1;
    m_ovld = 0;
    m_oid  = 0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_vec = '0;
    advance = 1'b0;
    lock    = 1'b0;
    arst_l  = 1'b0;
    #2;
    arst_l  = 1'b1;
    mdl_reset();
    #1;
    chk("rst_vld", int'(grant_vld), 0);
    chk("rst_id", int'(grant_id), 0);
  endtask

  function automatic bit has_req(input logic [N-1:0] r, input int i);
    return ((r >> i) & N'(1)) != '0;
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic cyc(input logic [N-1:0] r, input bit a, input bit l,
                     input logic [N*CW-1:0] w, output int gid, output int gvld);
    int g;
    int v;
    int ecnt;
    int wt;
    int idx;
    logic [N-1:0] mvec;
    @(negedge clk);
    req_vec    = r;
    advance    = a;
    lock       = l;
    weight_vec = w;
    #1;
    gid  = int'(grant_id);
    gvld = int'(grant_vld);
    v = 0;
    g = 0;
    if (m_ovld == 1 && has_req(r, m_oid)) begin
      v = 1;
      g = m_oid;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_park + k) % N;
        if (v == 0 && has_req(r, idx)) begin
          v = 1;
          g = idx;
        end
      end
    end
    mvec = (v == 1) ? (N'(1) << g) : '0;
    chk("mdl_vec", int'(grant_vec), int'(mvec));
    chk("mdl_id", gid, g);
    chk("mdl_vld", gvld, v);
    ecnt = (m_ovld == 1 && g == m_oid) ? m_cnt : 0;
    wt   = int'(w >> (g * CW)) % (1 << CW);
    if (a && v == 1) begin
      if (l) begin
        m_ovld = 1; m_oid = g; m_cnt = ecnt;
      end else if (ecnt < wt) begin
        m_ovld = 1; m_oid = g; m_cnt = ecnt + 1;
      end else begin
        m_ovld = 0; m_cnt = 0; m_park = g;
      end
    end else if (m_ovld == 1 && !has_req(r, m_oid)) begin
      m_ovld = 0; m_cnt = 0; m_park = m_oid;
    end
  endtask

  initial begin
    int gid;
    int gvld;
    logic [N-1:0]    r;
    logic [N*CW-1:0] w;
    bit a;
    bit l;

    // Plain round-robin from reset.
    tbl.push_back('{1, 4'b1111, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 1, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 2, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 3, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 0, 1});
    // Requester 1 weight 2: three consecutive grants, then 3, then back to 1.
    tbl.push_back('{1, 4'b0010, 1, 0, 8'h08, 1, 1});
    tbl.push_back('{0, 4'b1010, 1, 0, 8'h08, 1, 1});
    tbl.push_back('{0, 4'b1010, 1, 0, 8'h08, 1, 1});
    tbl.push_back('{0, 4'b1010, 1, 0, 8'h08, 3, 1});
    tbl.push_back('{0, 4'b1010, 1, 0, 8'h08, 1, 1});
    // Owner 2 drops its request mid-burst.
    tbl.push_back('{1, 4'b0100, 1, 0, 8'h30, 2, 1});
    tbl.push_back('{0, 4'b1001, 0, 0, 8'h30, 0, 1});
    tbl.push_back('{0, 4'b1001, 0, 0, 8'h30, 3, 1});
    // Lock holds requester 0, then release retires it.
    for (int i = 0; i < 5; i++) tbl.push_back('{(i == 0), 4'b1111, 1, 1, 8'h00, 0, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'b1111, 1, 0, 8'h00, 1, 1});
    // No requests: no grant, advance ignored, park kept.
    tbl.push_back('{1, 4'b1111, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'b0000, 1, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 4'b0000, 1, 0, 8'h00, 0, 0});
    tbl.push_back('{0, 4'b1111, 0, 0, 8'h00, 1, 1});
    // Weight lowered below current count retires immediately.
    tbl.push_back('{1, 4'b0011, 1, 0, 8'hFF, 0, 1});
    tbl.push_back('{0, 4'b0011, 1, 0, 8'hFF, 0, 1});
    tbl.push_back('{0, 4'b0011, 1, 0, 8'h00, 0, 1});
    tbl.push_back('{0, 4'b0011, 1, 0, 8'h00, 1, 1});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].req, tbl[i].adv, tbl[i].lk, tbl[i].wt, gid, gvld);
      chk($sformatf("tbl%0d_id", i), gid, tbl[i].exp_id);
      chk($sformatf("tbl%0d_vld", i), gvld, tbl[i].exp_vld);
    end

    // Park position after the owner abandons its request.
    do_reset();
    cyc(4'b0100, 1, 0, 8'h30, gid, gvld);
    cyc(4'b1001, 0, 0, 8'h30, gid, gvld);
    @(negedge clk);
    chk("park_after_drop", int'(dut.park), 4);

    // Asynchronous reset mid-burst, between clock edges.
    do_reset();
    cyc(4'b0100, 1, 0, 8'hFF, gid, gvld);
    cyc(4'b0100, 1, 0, 8'hFF, gid, gvld);
    @(negedge clk);
    req_vec = 4'b1111;
    advance = 1'b0;
    #1;
    chk("burst_owner_id", int'(grant_id), 2);
    arst_l = 1'b0;
    #1;
    chk("arst_id_low", int'(grant_id), 0);
    chk("arst_park", int'(dut.park), 8);
    arst_l = 1'b1;
    mdl_reset();
    #1;
    chk("arst_id", int'(grant_id), 0);
    chk("arst_owner", int'(dut.owner_vld), 0);

    // Random traffic against the model.
    w = 8'h00;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      a = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) w = 8'($urandom);
      cyc(r, a, l, w, gid, gvld);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
